aoi22_arc_sequencer: RTL and testbench
======================================

Name: aoi22_arc_sequencer

Overview:
- Built-in characterization/self-test sequencer for one 4-input AND-OR-INVERT (ZN = !((A1&A2)|(B1&B2))) cell under test.
- Walks all 12 sensitizing timing arcs of the cell in a fixed order.
- For each arc, drives the active pin low->high->low with the side pins held, samples ZN after a programmable settle time, and counts mismatches.
- Sits in the cell-library test harness between a test controller (start/abort) and the cell instance.

Parameters:
- SETTLE_CYCLES, 2, cycles each drive phase is held before ZN is sampled; legal range 1..255.
- STOP_ON_FAIL, 0, 1 = terminate the run at the first mismatch; 0 = run all arcs.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE.
- abort  input  1  terminate the run immediately; no done pulse.
- zn_in  input  1  ZN output of the cell under test.
- a1, a2, b1, b2  output  1 each  registered drive to the cell inputs.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes (normally or via STOP_ON_FAIL).
- pass  output  1  1 when the last completed run had zero mismatches; held until the next start.
- err_count  output  6  mismatches in the current/last run (max 36; no saturation needed).
- fail_arc  output  4  arc index of the first mismatch; 15 = none.
- fail_phase  output  2  phase of the first mismatch (0 SETUP, 1 RISE, 2 FALL); 3 = none.

Behaviour:
- Reset values: a1=a2=b1=b2=0, busy=0, done=0, pass=0, err_count=0, fail_arc=15, fail_phase=3, state=IDLE.
- States: IDLE, RUN, DONE.
- Arc table (index: active pin, side pins):
  - 0-2: A1; (A2,B1,B2) = 100, 101, 110.
  - 3-5: A2; (A1,B1,B2) = 100, 101, 110.
  - 6-8: B1; (A1,A2,B2) = 001, 011, 101.
  - 9-11: B2; (A1,A2,B1) = 001, 011, 101.
- Phases per arc: SETUP (active=0, expect ZN=1), RISE (active=1, expect 0), FALL (active=0, expect 1).
- IDLE:
  - All pins 0.
  - start=1 & abort=0 at an edge -> RUN with arc=0, phase=SETUP, settle counter=0.
  - On the same edge: err_count cleared, fail_arc=15, fail_phase=3, pass=0.
  - busy=1 from the next cycle.
- RUN:
  - Pins are a registered decode of (arc, phase).
  - Settle counter counts 0..SETTLE_CYCLES-1. At the edge where the count is SETTLE_CYCLES-1, zn_in is compared with the expected value.
  - On mismatch: err_count+1. If fail_arc==15, capture arc and phase.
  - Then advance: phase SETUP->RISE->FALL->next arc SETUP, with the counter reset. After arc 11 FALL -> DONE.
  - Run length = 36*SETTLE_CYCLES cycles.
- STOP_ON_FAIL=1: a mismatching sample moves to DONE on that same edge.
- DONE:
  - Lasts one cycle: done=1, busy=0, pins 0.
  - pass = (err_count==0), registered so it is valid with done.
  - Then -> IDLE.
- abort:
  - abort=1 in RUN -> IDLE at the next edge; pins 0, busy 0, no done.
  - err_count and fail_* keep partial values; pass stays 0.
  - In IDLE, abort wins over a simultaneous start (nothing starts).
- start while in RUN or DONE is ignored.
- zn_in is treated as synchronous to CK; no synchronizer in this block.
- RST asserted mid-run: all outputs return to reset values immediately (asynchronous).

Test Plan:
- Correct combinational AOI22 model, SETTLE_CYCLES=2, start pulse -> busy for 72 cycles, done pulse in cycle 73, pass=1, err_count=0, fail_arc=15, fail_phase=3.
- zn_in stuck at 1 -> err_count=12 (every RISE), fail_arc=0, fail_phase=1, pass=0; stuck at 0 -> err_count=24, fail_arc=0, fail_phase=0.
- Model with B2 input stuck at 0 -> RISE mismatches on arcs 6-11: err_count=6, fail_arc=6, fail_phase=1.
- STOP_ON_FAIL=1, zn_in stuck at 1 -> done pulse after the arc 0 RISE sample (cycle 5 of run), err_count=1, remaining arcs not driven.
- abort at run cycle 20 -> next cycle busy=0, pins 0, no done; start and abort together in IDLE -> stays IDLE; start during RUN -> no restart (err_count not cleared).
- RST pulsed at run cycle 30 -> pins, busy, err_count immediately 0, fail_arc=15; a new start afterwards completes a normal 72-cycle run.

Source files
------------

// File: rtl/aoi22_arc_sequencer.sv
// Self-test sequencer for one AOI22 cell: walks its 12 sensitizing arcs
// (SETUP/RISE/FALL each), samples ZN after a settle time and tallies mismatches.
module aoi22_arc_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          STOP_ON_FAIL  = 1'b0
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       start,
    input  logic       abort,
    input  logic       zn_in,
    output logic       a1,
    output logic       a2,
    output logic       b1,
    output logic       b2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_count,
    output logic [3:0] fail_arc,
    output logic [1:0] fail_phase,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_RISE  = 2'd1;
    localparam logic [1:0] PH_FALL  = 2'd2;
    localparam logic [3:0] ARC_NONE = 4'd15;
    localparam logic [1:0] PH_NONE  = 2'd3;
    localparam logic [3:0] ARC_LAST = 4'd11;
    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] arc_q, arc_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] err_q, err_d;
    logic [3:0] fail_arc_q, fail_arc_d;
    logic [1:0] fail_phase_q, fail_phase_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] pins_q, pins_d;
    logic       sample;
    logic       mismatch;

    // Drive pattern {a1,a2,b1,b2} for an arc; act is the level of its active pin.
    function automatic logic [3:0] arc_pins(input logic [3:0] arc, input logic act);
        logic [3:0] p;
        case (arc)
            4'd0:    p = {act, 1'b1, 1'b0, 1'b0};
            4'd1:    p = {act, 1'b1, 1'b0, 1'b1};
            4'd2:    p = {act, 1'b1, 1'b1, 1'b0};
            4'd3:    p = {1'b1, act, 1'b0, 1'b0};
            4'd4:    p = {1'b1, act, 1'b0, 1'b1};
            4'd5:    p = {1'b1, act, 1'b1, 1'b0};
            4'd6:    p = {1'b0, 1'b0, act, 1'b1};
            4'd7:    p = {1'b0, 1'b1, act, 1'b1};
            4'd8:    p = {1'b1, 1'b0, act, 1'b1};
            4'd9:    p = {1'b0, 1'b0, 1'b1, act};
            4'd10:   p = {1'b0, 1'b1, 1'b1, act};
            4'd11:   p = {1'b1, 1'b0, 1'b1, act};
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    assign sample   = (cnt_q == LAST_CNT);
    assign mismatch = sample && (zn_in != (phase_q != PH_RISE));

    // start/abort are level controls sampled on each rising CK edge: start is
    // taken only in IDLE with abort low; abort in RUN returns to IDLE with no done.
    always_comb begin
        state_d      = state_q;
        arc_d        = arc_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_arc_d   = fail_arc_q;
        fail_phase_d = fail_phase_q;
        pass_d       = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d      = ST_RUN;
                    arc_d        = 4'd0;
                    phase_d      = PH_SETUP;
                    cnt_d        = 8'd0;
                    err_d        = 6'd0;
                    fail_arc_d   = ARC_NONE;
                    fail_phase_d = PH_NONE;
                    pass_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sample) begin
                    cnt_d = 8'd0;
                    if (mismatch) begin
                        err_d = err_q + 6'd1;
                        if (fail_arc_q == ARC_NONE) begin
                            fail_arc_d   = arc_q;
                            fail_phase_d = phase_q;
                        end
                    end
                    if (mismatch && STOP_ON_FAIL) begin
                        state_d = ST_DONE;
                    end else if (phase_q == PH_FALL) begin
                        if (arc_q == ARC_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            arc_d   = arc_q + 4'd1;
                            phase_d = PH_SETUP;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                    if (state_d == ST_DONE) begin
                        pass_d = (err_d == 6'd0);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        pins_d = (state_d == ST_RUN) ? arc_pins(arc_d, phase_d == PH_RISE) : 4'b0000;
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            arc_q        <= 4'd0;
            phase_q      <= PH_SETUP;
            cnt_q        <= 8'd0;
            err_q        <= 6'd0;
            fail_arc_q   <= ARC_NONE;
            fail_phase_q <= PH_NONE;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pins_q       <= 4'b0000;
        end else begin
            state_q      <= state_d;
            arc_q        <= arc_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_arc_q   <= fail_arc_d;
            fail_phase_q <= fail_phase_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pins_q       <= pins_d;
        end
    end

    assign {a1, a2, b1, b2} = pins_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_arc   = fail_arc_q;
    assign fail_phase = fail_phase_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_aoi22_arc_sequencer.sv
// Bench for aoi22_arc_sequencer: fault-injected AOI22 cell model, table vectors,
// hand sequences for abort/restart/reset and random faults against a run predictor.
module tb_aoi22_arc_sequencer;
    localparam int S       = 2;
    localparam int RUN_LEN = 36 * S;

    logic CK, RST, start_m, abort_m, sel;
    int   fpin;
    logic fval;

    logic start_0, abort_0, zn_0, a1_0, a2_0, b1_0, b2_0, busy_0, done_0, pass_0;
    logic [5:0] err_0; logic [3:0] farc_0; logic [1:0] fph_0, dbg_0;
    logic start_1, abort_1, zn_1, a1_1, a2_1, b1_1, b2_1, busy_1, done_1, pass_1;
    logic [5:0] err_1; logic [3:0] farc_1; logic [1:0] fph_1, dbg_1;

    logic [3:0] o_pins; logic o_busy, o_done, o_pass;
    logic [5:0] o_err; logic [3:0] o_farc; logic [1:0] o_fph;

    logic [3:0] side_tbl [12];
    int n_tests, n_fail;

    // Cell under test: fpin 0..3 sticks a1/a2/b1/b2 at fval, 4 sticks ZN, else healthy.
    function automatic logic cell_zn(input logic [3:0] p, input int fp, input logic fv);
        logic [3:0] q;
        q = p;
        if (fp >= 0 && fp < 4) q[3-fp] = fv;
        if (fp == 4) return fv;
        return !((q[3] & q[2]) | (q[1] & q[0]));
    endfunction

    function automatic logic [3:0] exp_pins(input int arc, input int ph);
        logic [3:0] mask;
        if (arc > 11) return 4'b0000;
        mask = 4'b1000 >> (arc / 3);
        return side_tbl[arc] | ((ph == 1) ? mask : 4'b0000);
    endfunction

    // Predicts a whole run from the arc list, phase expectations and fault.
    task automatic model_run(input int fp, input logic fv, input bit stop,
                             output int err, output int farc, output int fph, output int cyc);
        bit stopped;
        err = 0; farc = 15; fph = 3; cyc = RUN_LEN; stopped = 0;
        for (int arc = 0; arc < 12; arc++) begin
            for (int ph = 0; ph < 3; ph++) begin
                if (!stopped && cell_zn(exp_pins(arc, ph), fp, fv) != (ph != 1)) begin
                    err++;
                    if (farc == 15) begin farc = arc; fph = ph; end
                    if (stop) begin stopped = 1; cyc = (arc * 3 + ph + 1) * S; end
                end
            end
        end
    endtask

    aoi22_arc_sequencer #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b0)) dut (
        .CK(CK), .RST(RST), .start(start_0), .abort(abort_0), .zn_in(zn_0),
        .a1(a1_0), .a2(a2_0), .b1(b1_0), .b2(b2_0), .busy(busy_0), .done(done_0),
        .pass(pass_0), .err_count(err_0), .fail_arc(farc_0), .fail_phase(fph_0),
        .dbg_state(dbg_0));

    aoi22_arc_sequencer #(.SETTLE_CYCLES(S), .STOP_ON_FAIL(1'b1)) dut_sof (
        .CK(CK), .RST(RST), .start(start_1), .abort(abort_1), .zn_in(zn_1),
        .a1(a1_1), .a2(a2_1), .b1(b1_1), .b2(b2_1), .busy(busy_1), .done(done_1),
        .pass(pass_1), .err_count(err_1), .fail_arc(farc_1), .fail_phase(fph_1),
        .dbg_state(dbg_1));

    assign start_0 = start_m & ~sel;
    assign abort_0 = abort_m & ~sel;
    assign start_1 = start_m & sel;
    assign abort_1 = abort_m & sel;
    assign zn_0 = cell_zn({a1_0, a2_0, b1_0, b2_0}, fpin, fval);
    assign zn_1 = cell_zn({a1_1, a2_1, b1_1, b2_1}, fpin, fval);

    always_comb begin
        if (sel) begin
            o_pins = {a1_1, a2_1, b1_1, b2_1}; o_busy = busy_1; o_done = done_1;
            o_pass = pass_1; o_err = err_1; o_farc = farc_1; o_fph = fph_1;
        end else begin
            o_pins = {a1_0, a2_0, b1_0, b2_0}; o_busy = busy_0; o_done = done_0;
            o_pass = pass_0; o_err = err_0; o_farc = farc_0; o_fph = fph_0;
        end
    end

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
    endtask

    // Follows a run cycle by cycle; optionally raises start at run cycle restart_at.
    task automatic follow_run(input int restart_at, output int cycles,
                              output int seq_errs, output int err_mid);
        cycles = 0; seq_errs = 0; err_mid = -1;
        while (o_busy === 1'b1 && cycles < RUN_LEN + 20) begin
            cycles++;
            if (o_pins !== exp_pins((cycles - 1) / S / 3, ((cycles - 1) / S) % 3)) seq_errs++;
            if (o_done !== 1'b0) seq_errs++;
            if (cycles == restart_at + 1) err_mid = int'(o_err);
            start_m = (cycles == restart_at);
            tick();
        end
        start_m = 1'b0;
    endtask

    task automatic check_end(input string nm, input int cycles, input int seq_errs,
                             input int e_cyc, input int e_err, input int e_arc,
                             input int e_ph, input int e_pass);
        chk({nm, " cycles"}, cycles, e_cyc);
        chk({nm, " pin_seq"}, seq_errs, 0);
        chk({nm, " done"}, int'(o_done), 1);
        chk({nm, " done_busy"}, int'(o_busy), 0);
        chk({nm, " done_pins"}, int'(o_pins), 0);
        chk({nm, " err_count"}, int'(o_err), e_err);
        chk({nm, " fail_arc"}, int'(o_farc), e_arc);
        chk({nm, " fail_phase"}, int'(o_fph), e_ph);
        chk({nm, " pass"}, int'(o_pass), e_pass);
        tick();
        chk({nm, " done_one_cycle"}, int'({o_done, o_busy}), 0);
        chk({nm, " pass_held"}, int'(o_pass), e_pass);
    endtask

    typedef struct {
        string name;
        int    fp;
        logic  fv;
        int    e_err;
        int    e_arc;
        int    e_ph;
        int    e_pass;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cyc, sq, mid, e_err, e_arc, e_ph, e_cyc;
        n_tests = 0; n_fail = 0;
        side_tbl = '{4'b0100, 4'b0101, 4'b0110, 4'b1000, 4'b1001, 4'b1010,
                     4'b0001, 4'b0101, 4'b1001, 4'b0010, 4'b0110, 4'b1010};
        vecs[0] = '{"healthy",   5, 1'b0,  0, 15, 3, 1};
        vecs[1] = '{"zn_sa1",    4, 1'b1, 12,  0, 1, 0};
        vecs[2] = '{"zn_sa0",    4, 1'b0, 24,  0, 0, 0};
        vecs[3] = '{"b2_sa0",    3, 1'b0,  6,  6, 1, 0};
        vecs[4] = '{"a1_sa0",    0, 1'b0,  6,  0, 1, 0};
        vecs[5] = '{"a1_sa1",    0, 1'b1, 10,  0, 0, 0};

        start_m = 0; abort_m = 0; sel = 0; fpin = 5; fval = 0;
        RST = 0;
        #1 RST = 1;
        #6;
        chk("rst pins", int'(o_pins), 0);
        chk("rst busy_done_pass", int'({o_busy, o_done, o_pass}), 0);
        chk("rst err_count", int'(o_err), 0);
        chk("rst fail_arc", int'(o_farc), 15);
        chk("rst fail_phase", int'(o_fph), 3);
        #5 RST = 0;
        tick();
        chk("post_rst idle", int'({o_busy, o_done, o_pins}), 0);

        for (int i = 0; i < 6; i++) begin
            fpin = vecs[i].fp; fval = vecs[i].fv;
            tick();
            pulse_start();
            follow_run(-1, cyc, sq, mid);
            check_end(vecs[i].name, cyc, sq, RUN_LEN, vecs[i].e_err,
                      vecs[i].e_arc, vecs[i].e_ph, vecs[i].e_pass);
        end

        // Stop-on-fail instance: done right after the arc 0 RISE sample.
        sel = 1; fpin = 4; fval = 1;
        tick();
        pulse_start();
        follow_run(-1, cyc, sq, mid);
        check_end("sof_zn_sa1", cyc, sq, 4, 1, 0, 1, 0);
        sq = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_pins !== 4'b0000 || o_busy !== 1'b0) sq++;
            tick();
        end
        chk("sof no further arcs", sq, 0);
        fpin = 5;
        pulse_start();
        follow_run(-1, cyc, sq, mid);
        check_end("sof_healthy", cyc, sq, RUN_LEN, 0, 15, 3, 1);
        sel = 0;
        tick();

        // Abort at run cycle 20.
        pulse_start();
        repeat (19) tick();
        chk("abort pre busy", int'(o_busy), 1);
        abort_m = 1;
        tick();
        abort_m = 0;
        chk("abort busy", int'(o_busy), 0);
        chk("abort pins", int'(o_pins), 0);
        chk("abort pass", int'(o_pass), 0);
        sq = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_done !== 1'b0) sq++;
            tick();
        end
        chk("abort no done", sq, 0);

        // start and abort together in IDLE: nothing starts.
        start_m = 1; abort_m = 1;
        tick();
        start_m = 0; abort_m = 0;
        chk("start+abort busy", int'(o_busy), 0);
        tick();
        chk("start+abort idle", int'({o_busy, o_pins}), 0);

        // start during RUN is ignored.
        fpin = 4; fval = 1;
        pulse_start();
        follow_run(8, cyc, sq, mid);
        chk("restart err kept", mid, 1);
        check_end("restart_ignored", cyc, sq, RUN_LEN, 12, 0, 1, 0);

        // Asynchronous reset at run cycle 30.
        pulse_start();
        repeat (29) tick();
        chk("pre_rst err_count", int'(o_err), 5);
        #2 RST = 1;
        #1;
        chk("async rst pins", int'(o_pins), 0);
        chk("async rst busy", int'(o_busy), 0);
        chk("async rst err_count", int'(o_err), 0);
        chk("async rst fail", int'({o_farc, o_fph}), 63);
        RST = 0;
        fpin = 5;
        tick();
        pulse_start();
        follow_run(-1, cyc, sq, mid);
        check_end("after_rst", cyc, sq, RUN_LEN, 0, 15, 3, 1);

        // Random fault / instance selection against the run predictor.
        for (int i = 0; i < 12; i++) begin
            sel  = 1'($urandom_range(0, 1));
            fpin = $urandom_range(0, 5);
            fval = 1'($urandom_range(0, 1));
            model_run(fpin, fval, sel, e_err, e_arc, e_ph, e_cyc);
            tick();
            pulse_start();
            follow_run(-1, cyc, sq, mid);
            check_end($sformatf("rand%0d", i), cyc, sq, e_cyc, e_err, e_arc, e_ph,
                      (e_err == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
